// File: rtl/cmp_16b_struct.sv
`default_nettype none
// ============================================================================
// Module      : cmp_16b_struct
// Description : Registered WIDTH-bit magnitude comparator built from 4-bit
//               leaf slices merged MSB-first through a pairwise tree.
//               Define CMP_SIGNED_EN for a two's-complement compare.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_16b_struct #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_is_equal,
    output logic             a_is_greater,
    output logic             a_is_smaller,
    output logic             out_valid
);

    localparam int SLICE_W = 4;
    localparam int NG      = WIDTH / SLICE_W;
    localparam int LEVELS  = $clog2(NG);

`ifdef CMP_SIGNED_EN
    localparam logic c_SIGNED = 1'b1;
`else
    localparam logic c_SIGNED = 1'b0;
`endif

    // Number of nodes present at a given tree level (odd leftovers pass up).
    function automatic int f_cnt(input int lvl);
        int c;
        c = NG;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    logic w_root_eq;
    logic w_root_gt;
    logic w_root_lt;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = f_cnt(l);
        logic [N-1:0] w_eq;
        logic [N-1:0] w_gt;
        logic [N-1:0] w_lt;

        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < NG; k++) begin : g_slice
                // Inverting the sign bit of both operands turns an unsigned
                // compare of the top slice into a two's-complement one.
                localparam logic [SLICE_W-1:0] c_FLIP =
                    (k == NG - 1) ? {c_SIGNED, 3'b000} : 4'b0000;
                logic [SLICE_W-1:0] w_sa;
                logic [SLICE_W-1:0] w_sb;
                logic [SLICE_W-1:0] w_x;
                logic [SLICE_W-1:0] w_win;

                assign w_sa  = a[k*SLICE_W +: SLICE_W] ^ c_FLIP;
                assign w_sb  = b[k*SLICE_W +: SLICE_W] ^ c_FLIP;
                assign w_x   = ~(w_sa ^ w_sb);
                assign w_win = w_sa & ~w_sb;

                assign w_eq[k] = &w_x;
                assign w_gt[k] = w_win[3]
                               | (w_x[3] & w_win[2])
                               | (&w_x[3:2] & w_win[1])
                               | (&w_x[3:1] & w_win[0]);
                assign w_lt[k] = ~w_eq[k] & ~w_gt[k];
            end
        end else begin : g_merge
            localparam int NP = f_cnt(l - 1);
            for (genvar j = 0; j < N; j++) begin : g_node
                if (2 * j + 1 < NP) begin : g_pair
                    logic w_eqh, w_gth, w_lth, w_eql, w_gtl, w_ltl;
                    assign w_eqh = g_lvl[l-1].w_eq[2*j+1];
                    assign w_gth = g_lvl[l-1].w_gt[2*j+1];
                    assign w_lth = g_lvl[l-1].w_lt[2*j+1];
                    assign w_eql = g_lvl[l-1].w_eq[2*j];
                    assign w_gtl = g_lvl[l-1].w_gt[2*j];
                    assign w_ltl = g_lvl[l-1].w_lt[2*j];

                    assign w_eq[j] = w_eqh & w_eql;
                    assign w_gt[j] = w_gth | (w_eqh & w_gtl);
                    assign w_lt[j] = w_lth | (w_eqh & w_ltl);
                end else begin : g_pass
                    assign w_eq[j] = g_lvl[l-1].w_eq[2*j];
                    assign w_gt[j] = g_lvl[l-1].w_gt[2*j];
                    assign w_lt[j] = g_lvl[l-1].w_lt[2*j];
                end
            end
        end
    end

    assign w_root_eq = g_lvl[LEVELS].w_eq[0];
    assign w_root_gt = g_lvl[LEVELS].w_gt[0];
    assign w_root_lt = g_lvl[LEVELS].w_lt[0];

    logic eq_q, gt_q, lt_q, vld_q;
    logic eq_d, gt_d, lt_d;

    // Flags hold their last qualified result while in_valid is low.
    always_comb begin
        eq_d = eq_q;
        gt_d = gt_q;
        lt_d = lt_q;
        if (in_valid) begin
            eq_d = w_root_eq;
            gt_d = w_root_gt;
            lt_d = w_root_lt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            eq_q  <= eq_d;
            gt_q  <= gt_d;
            lt_q  <= lt_d;
            vld_q <= in_valid;
        end
    end

    assign a_is_equal   = eq_q;
    assign a_is_greater = gt_q;
    assign a_is_smaller = lt_q;
    assign out_valid    = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_16b_struct.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_16b_struct
// Description : Self-checking bench for cmp_16b_struct (16-bit, either build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_16b_struct;

    localparam logic [2:0] E = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] S = 3'b001;

`ifdef CMP_SIGNED_EN
    localparam logic [2:0] FFFF_VS_0 = S;
    localparam logic [2:0] ZERO_VS_FFFF = G;
    localparam logic [2:0] X8000_VS_1 = S;
`else
    localparam logic [2:0] FFFF_VS_0 = G;
    localparam logic [2:0] ZERO_VS_FFFF = S;
    localparam logic [2:0] X8000_VS_1 = G;
`endif

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        a_is_equal;
    logic        a_is_greater;
    logic        a_is_smaller;
    logic        out_valid;

    int          n_vec;
    int          n_bad;
    logic [2:0]  held;

    cmp_16b_struct #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .a_is_equal   (a_is_equal),
        .a_is_greater (a_is_greater),
        .a_is_smaller (a_is_smaller),
        .out_valid    (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y);
`ifdef CMP_SIGNED_EN
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
`else
        int sx, sy;
        sx = int'({16'h0, x});
        sy = int'({16'h0, y});
`endif
        if (sx > sy) return G;
        if (sx < sy) return S;
        return E;
    endfunction

    task automatic check(input string nm, input logic ev, input logic [2:0] ef);
        logic [3:0] got, req;
        got = {out_valid, a_is_equal, a_is_greater, a_is_smaller};
        req = {ev, ef};
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: a=%h b=%h got vld/eq/gt/lt=%b required=%b",
                     nm, a, b, got, req);
        end
    endtask

    // Drive one cycle, then check the registered result 1 ns after the edge.
    task automatic apply(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic [2:0] exp, input string nm);
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb_;
        @(posedge clk);
        if (v) held = exp;
        #1;
        check(nm, v, held);
    endtask

    task automatic apply_model(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                               input string nm);
        apply(v, ta, tb_, ref_cmp(ta, tb_), nm);
    endtask

    vec_t dir [0:10];
    vec_t b2b [0:3];

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        held     = 3'b000;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;

        dir[0]  = '{1'b1, 16'hFFFF, 16'h0000, FFFF_VS_0};
        dir[1]  = '{1'b1, 16'h0000, 16'hFFFF, ZERO_VS_FFFF};
        dir[2]  = '{1'b1, 16'hFFFF, 16'hFFFF, E};
        dir[3]  = '{1'b1, 16'h0000, 16'h0000, E};
        dir[4]  = '{1'b1, 16'h1234, 16'h1235, S};
        dir[5]  = '{1'b1, 16'h0100, 16'h00FF, G};
        dir[6]  = '{1'b1, 16'h1000, 16'h0FFF, G};
        dir[7]  = '{1'b1, 16'h8000, 16'h0001, X8000_VS_1};
        dir[8]  = '{1'b1, 16'h0001, 16'h0000, G};
        dir[9]  = '{1'b1, 16'h7FFE, 16'h7FFF, S};
        dir[10] = '{1'b1, 16'hABCD, 16'hABCD, E};

        b2b[0] = '{1'b1, 16'd3, 16'd3, E};
        b2b[1] = '{1'b1, 16'd4, 16'd3, G};
        b2b[2] = '{1'b1, 16'd3, 16'd4, S};
        b2b[3] = '{1'b1, 16'd0, 16'd0, E};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1'b0, 3'b000);

        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 16'd5, 16'd5, E, "post_reset_eq");

        for (int i = 0; i < 11; i++) begin
            apply(dir[i].v, dir[i].a, dir[i].b, dir[i].exp, $sformatf("directed_%0d", i));
        end

        apply(1'b1, 16'd9, 16'd3, G, "gate_load");
        apply(1'b0, 16'd1, 16'd7, S, "gate_hold");
        apply(1'b0, 16'd2, 16'd2, E, "gate_hold2");

        for (int i = 0; i < 4; i++) begin
            apply(b2b[i].v, b2b[i].a, b2b[i].b, b2b[i].exp, $sformatf("b2b_%0d", i));
        end

        // Asynchronous reset mid-cycle with a compare in flight.
        apply(1'b1, 16'hFFFF, 16'hFFFF, E, "pre_reset");
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'd3;
        b        = 16'd4;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 3'b000);
        held = 3'b000;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset_discard", 1'b0, 3'b000);
        apply(1'b1, 16'd7, 16'd7, E, "first_after_reset");

        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                apply_model(1'b1, 16'(i), 16'(j), "sweep");
            end
        end

        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [15:0] ra, rb;
            rv = ($urandom_range(0, 7) != 0);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? ra : 16'($urandom);
            apply_model(rv, ra, rb, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
